// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;

  typedef enum logic [1:0] {NOP, ADD, SUB} booth_op_e;

  // Radix-2 Booth recoding of {P_lo[0], q_-1}.
  function automatic booth_op_e booth_decode(input logic [1:0] pair);
    case (pair)
      2'b01:   return ADD;
      2'b10:   return SUB;
      default: return NOP;
    endcase
  endfunction

endpackage

// File: rtl/multdiv_unit_booth_step.sv
// One radix-2 Booth iteration: add/sub multiplicand into P_hi, then arithmetic shift right.
module booth_step
  import multdiv_pkg::*;
(
  input  logic [WIDTH-1:0] p_hi_i,
  input  logic [WIDTH-1:0] p_lo_i,
  input  logic             q_m1_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [2*WIDTH:0] prod_o
);

  logic [WIDTH:0] hi_ext;
  logic [WIDTH:0] mc_ext;
  logic [WIDTH:0] sum;

  // Sum is kept one bit wider so a -INT_MIN step cannot wrap before the shift.
  always_comb begin
    hi_ext = {p_hi_i[WIDTH-1], p_hi_i};
    mc_ext = {mcand_i[WIDTH-1], mcand_i};
    case (booth_decode({p_lo_i[0], q_m1_i}))
      ADD:     sum = hi_ext + mc_ext;
      SUB:     sum = hi_ext - mc_ext;
      default: sum = hi_ext;
    endcase
    prod_o = {sum, p_lo_i};
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (Booth) / divide (restoring) with fixed 32-cycle latency.
module multdiv_unit
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   prod_q, prod_d, prod_nx;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   rem_q, rem_d, rem_nx;
  logic [WIDTH-1:0]   quo_q, quo_d, quo_nx;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               neg_q, neg_d;
  logic               dvz_q, dvz_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     shl, trial;
  logic [2*WIDTH-1:0] product;
  logic               last;

  booth_step u_booth (
    .p_hi_i  (prod_q[2*WIDTH:WIDTH+1]),
    .p_lo_i  (prod_q[WIDTH:1]),
    .q_m1_i  (prod_q[0]),
    .mcand_i (mcand_q),
    .prod_o  (prod_nx)
  );

  // INT_MIN negates to itself, which is the correct unsigned magnitude.
  assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // Partial remainder stays below the divisor, so the shifted value never sets bit WIDTH.
  assign shl    = {rem_q, quo_q[WIDTH-1]};
  assign trial  = shl - {1'b0, dvsr_q};
  assign rem_nx = trial[WIDTH] ? shl[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nx = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

  assign product = prod_nx[2*WIDTH:1];
  assign last    = (cnt_q == CNT_W'(WIDTH-1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      neg_q    <= 1'b0;
      dvz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      neg_q    <= neg_d;
      dvz_q    <= dvz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    neg_d    = neg_q;
    dvz_d    = dvz_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    exc_d    = exc_q;

    // A start in any state aborts whatever is running; MULT wins a tie.
    if (ctrl_MULT) begin
      state_d = MULT;
      cnt_d   = '0;
      prod_d  = {{WIDTH{1'b0}}, data_operandB, 1'b0};
      mcand_d = data_operandA;
    end else if (ctrl_DIV) begin
      state_d = DIV;
      cnt_d   = '0;
      rem_d   = '0;
      quo_d   = abs_a;
      dvsr_d  = abs_b;
      neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dvz_d   = (data_operandB == '0);
      ovf_d   = (data_operandA == INT_MIN) && (data_operandB == '1);
    end else begin
      case (state_q)
        MULT: begin
          prod_d = prod_nx;
          cnt_d  = cnt_q + 1'b1;
          if (last) begin
            state_d  = DONE;
            cnt_d    = '0;
            result_d = product[WIDTH-1:0];
            exc_d    = !((&product[2*WIDTH-1:WIDTH-1]) || !(|product[2*WIDTH-1:WIDTH-1]));
          end
        end
        DIV: begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            state_d  = DONE;
            cnt_d    = '0;
            result_d = dvz_q ? '0 : (neg_q ? -quo_nx : quo_nx);
            exc_d    = dvz_q | ovf_q;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);

endmodule
